// File: rtl/maze_wall_follower_if.sv
// Run-control and maze/path bus between the maze loader (master) and the wall follower (slave).
// Parameters must match the attached maze_wall_follower instance.
interface maze_wall_follower_if #(
    parameter int SIZE      = 9,
    parameter int MAX_STEPS = 255
);
    localparam int N  = $clog2(SIZE);
    localparam int SW = $clog2(MAX_STEPS + 1);

    logic [SIZE-1:0][SIZE-1:0] maze;
    logic                      start;
    logic                      hand;
    logic                      busy;
    logic                      done;
    logic                      found;
    logic                      timeout;
    logic [N-1:0]              x;
    logic [N-1:0]              y;
    logic [SW-1:0]             steps;
    logic [SIZE-1:0][SIZE-1:0] path;

    modport master (
        output maze, start, hand,
        input  busy, done, found, timeout, x, y, steps, path
    );

    modport slave (
        input  maze, start, hand,
        output busy, done, found, timeout, x, y, steps, path
    );
endinterface

// File: rtl/maze_wall_follower.sv
// SIZE x SIZE wall-following maze solver with start/done handshake, step count and step-limit timeout.
// One move per cycle; start ignored while busy. MAZE_PATH_PRUNE_EN: reversing moves erase the cell left.
module maze_wall_follower #(
    parameter int SIZE      = 9,
    parameter int MAX_STEPS = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    maze_wall_follower_if.slave  bus
);
    localparam int N  = $clog2(SIZE);
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam logic [N-1:0]  LAST  = N'(SIZE - 1);
    localparam logic [N-1:0]  ONE   = N'(1);
    localparam logic [SW-1:0] ONE_S = SW'(1);
    localparam logic [SW-1:0] LIMIT = SW'(MAX_STEPS);

    typedef enum logic [2:0] {IDLE, FIND_EXIT, FIND_ENTRY, WALK, DONE} state_t;
    // Clockwise order with y growing downwards: +1 is a right turn.
    typedef enum logic [1:0] {HD_E = 2'd0, HD_S = 2'd1, HD_W = 2'd2, HD_N = 2'd3} heading_t;

    state_t                    state, state_nxt;
    heading_t                  heading, heading_nxt;
    logic                      hand_q, hand_nxt;
    logic [N-1:0]              x, x_nxt, y, y_nxt, ex, ex_nxt;
    logic [SW-1:0]             steps, steps_nxt;
    logic                      found, found_nxt, timeout, timeout_nxt;
    logic [SIZE-1:0][SIZE-1:0] path, path_nxt;

    logic [3:0]                open;
    logic [3:0][N-1:0]         nx, ny;
    logic                      mv_ok;
    logic [1:0]                mv_dir;

    function automatic logic [1:0] prio_off(input logic left, input logic [1:0] k);
        case (k)
            2'd0:    prio_off = left ? 2'd3 : 2'd1;
            2'd1:    prio_off = 2'd0;
            2'd2:    prio_off = left ? 2'd1 : 2'd3;
            default: prio_off = 2'd2;
        endcase
    endfunction

    // Neighbour coordinates are only formed inside the grid; outside cells stay closed.
    always_comb begin
        nx   = {4{x}};
        ny   = {4{y}};
        open = '0;
        if (x != LAST) begin
            nx[HD_E]   = x + ONE;
            open[HD_E] = !bus.maze[y][nx[HD_E]];
        end
        if (y != LAST) begin
            ny[HD_S]   = y + ONE;
            open[HD_S] = !bus.maze[ny[HD_S]][x];
        end
        if (x != '0) begin
            nx[HD_W]   = x - ONE;
            open[HD_W] = !bus.maze[y][nx[HD_W]];
        end
        if (y != '0) begin
            ny[HD_N]   = y - ONE;
            open[HD_N] = !bus.maze[ny[HD_N]][x];
        end
    end

    always_comb begin
        logic [1:0] cand;
        mv_ok  = 1'b0;
        mv_dir = heading;
        cand   = heading;
        for (int k = 0; k < 4; k++) begin
            cand = heading + prio_off(hand_q, 2'(k));
            if (!mv_ok && open[cand]) begin
                mv_ok  = 1'b1;
                mv_dir = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        heading_nxt = heading;
        hand_nxt    = hand_q;
        x_nxt       = x;
        y_nxt       = y;
        ex_nxt      = ex;
        steps_nxt   = steps;
        found_nxt   = found;
        timeout_nxt = timeout;
        path_nxt    = path;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt   = FIND_EXIT;
                    heading_nxt = HD_S;
                    hand_nxt    = bus.hand;
                    x_nxt       = '0;
                    y_nxt       = '0;
                    ex_nxt      = '0;
                    steps_nxt   = '0;
                    found_nxt   = 1'b0;
                    timeout_nxt = 1'b0;
                    path_nxt    = '0;
                end
            end
            FIND_EXIT: begin
                if (!bus.maze[LAST][x]) begin
                    ex_nxt    = x;
                    x_nxt     = '0;
                    state_nxt = FIND_ENTRY;
                end else if (x == LAST) begin
                    state_nxt = DONE;
                end else begin
                    x_nxt = x + ONE;
                end
            end
            FIND_ENTRY: begin
                if (!bus.maze[0][x]) begin
                    path_nxt[0][x] = 1'b1;
                    state_nxt      = WALK;
                end else if (x == LAST) begin
                    state_nxt = DONE;
                end else begin
                    x_nxt = x + ONE;
                end
            end
            WALK: begin
                if (!mv_ok) begin
                    state_nxt = DONE;
                end else begin
                    heading_nxt = heading_t'(mv_dir);
                    x_nxt       = nx[mv_dir];
                    y_nxt       = ny[mv_dir];
                    steps_nxt   = steps + ONE_S;
`ifdef MAZE_PATH_PRUNE_EN
                    if (mv_dir == 2'(heading + 2'd2))
                        path_nxt[y][x] = 1'b0;
`endif
                    path_nxt[ny[mv_dir]][nx[mv_dir]] = 1'b1;
                    if (nx[mv_dir] == ex && ny[mv_dir] == LAST) begin
                        found_nxt = 1'b1;
                        state_nxt = DONE;
                    end else if (steps + ONE_S == LIMIT) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            heading <= HD_S;
            hand_q  <= 1'b0;
            x       <= '0;
            y       <= '0;
            ex      <= '0;
            steps   <= '0;
            found   <= 1'b0;
            timeout <= 1'b0;
            path    <= '0;
        end else begin
            state   <= state_nxt;
            heading <= heading_nxt;
            hand_q  <= hand_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
            ex      <= ex_nxt;
            steps   <= steps_nxt;
            found   <= found_nxt;
            timeout <= timeout_nxt;
            path    <= path_nxt;
        end
    end

    assign bus.busy    = (state == FIND_EXIT) || (state == FIND_ENTRY) || (state == WALK);
    assign bus.done    = (state == DONE);
    assign bus.found   = found;
    assign bus.timeout = timeout;
    assign bus.x       = x;
    assign bus.y       = y;
    assign bus.steps   = steps;
    assign bus.path    = path;
endmodule
